// File: rtl/booth_mult_arbiter_if.sv
// Signal bundle between booth_mult_arbiter, its requester clients and the multiplier core.
// slave is the arbiter's view; master is the view of the surrounding clients and core.
interface booth_mult_arbiter_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic [NREQ-1:0]    req_ready;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [31:0]        rsp_prod;
    logic               rsp_err;

    logic               m_en;
    logic [15:0]        m_a;
    logic [15:0]        m_b;
    logic [31:0]        m_prod;
    logic               m_done;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, m_prod, m_done,
        output req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, m_en, m_a, m_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, m_prod, m_done,
        input  req_ready, rsp_valid, rsp_id, rsp_prod, rsp_err, m_en, m_a, m_b
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential Booth multiplier core among NREQ clients.
// Optional watchdog abort of a stuck core is enabled by defining BOOTH_MULT_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    booth_mult_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic            grant_found;
    logic [15:0]     grant_a;
    logic [15:0]     grant_b;
    logic [ID_W-1:0] job_id;
    logic [15:0]     a_q;
    logic [15:0]     b_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [31:0]     rsp_prod_q;
    logic            wdog_expired;
    int              best_dist;

    if (NREQ < 2 || NREQ > 8 || NREQ > (1 << ID_W) || TIMEOUT < 1) begin : g_bad_params
        $error("booth_mult_arbiter: illegal NREQ/ID_W/TIMEOUT combination");
    end

    // Grant the valid requester closest to rr_ptr in upward, wrapping order.
    always_comb begin : p_grant
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant       = '0;
        grant_found = 1'b0;
        grant_a     = '0;
        grant_b     = '0;
        best_dist   = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && ((i - int'(rr_ptr) + NREQ) % NREQ) < best_dist) begin
                best_dist   = (i - int'(rr_ptr) + NREQ) % NREQ;
                grant       = ID_W'(i);
                grant_found = 1'b1;
                grant_a     = bus.req_a[16*i +: 16];
                grant_b     = bus.req_b[16*i +: 16];
            end
        end
    end

    always_comb begin : p_next_state
        state_next = state;
        unique case (state)
            IDLE:    if (grant_found) state_next = RUN;
            RUN:     if (bus.m_done || wdog_expired) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : p_state_reg
        // NOTE: sequential state is updated with non-blocking assignments so all flops sample together.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin : p_datapath
        if (rst) begin
            rr_ptr      <= '0;
            job_id      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_q    <= grant_a;
                        b_q    <= grant_b;
                        job_id <= grant;
                        rr_ptr <= ID_W'((int'(grant) + 1) % NREQ);
                    end
                end
                RUN: begin
                    if (bus.m_done) begin
                        rsp_prod_q  <= bus.m_prod;
                        rsp_id_q    <= job_id;
                        rsp_valid_q <= 1'b1;
                    end else if (wdog_expired) begin
                        rsp_prod_q  <= '0;
                        rsp_id_q    <= job_id;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef BOOTH_MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wdog_cnt;
    logic             rsp_err_q;

    // Counter idles at zero outside RUN, so it restarts on every job.
    assign wdog_expired = (state == RUN) && !bus.m_done && (wdog_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin : p_watchdog
        if (rst) begin
            wdog_cnt  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state != RUN) begin
                wdog_cnt <= '0;
            end else if (!bus.m_done && !wdog_expired) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (state == RUN) begin
                if (bus.m_done) begin
                    rsp_err_q <= 1'b0;
                end else if (wdog_expired) begin
                    rsp_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign wdog_expired = 1'b0;
    assign bus.rsp_err  = 1'b0;
`endif

    // Core is enabled only in RUN; IDLE and RESP both hold it cleared.
    assign bus.m_en      = (state == RUN);
    assign bus.m_a       = a_q;
    assign bus.m_b       = b_q;
    assign bus.req_ready = (state == IDLE && !rst && grant_found) ? (NREQ'(1) << grant) : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter: directed scenarios plus randomized client traffic,
// compared cycle by cycle against a transaction-level model of arbitration, latency and products.
module tb_booth_mult_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int CORE_LAT = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mult_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    booth_mult_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    // Core model: done rises CORE_LAT edges after enable rises, cleared whenever enable is low.
    int core_cnt;
    always @(posedge clk) begin
        if (!bus.m_en) core_cnt <= 0;
        else if (core_cnt < CORE_LAT) core_cnt <= core_cnt + 1;
    end
    assign bus.m_done = bus.m_en && (core_cnt == CORE_LAT);
    assign bus.m_prod = bus.m_done ? mul16(bus.m_a, bus.m_b) : 32'hDEAD_BEEF;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state: pending client operands and the arbiter's job at transaction level.
    bit          pv[NREQ];
    logic [15:0] pa[NREQ];
    logic [15:0] pb[NREQ];
    int          ptr;
    bit          running;
    int          age;
    int          job_id_m;
    logic [15:0] job_a;
    logic [15:0] job_b;
    int          hold_left;
    int          bp_fixed;
    bit          cont_mode;
    bit          rand_mode;
    int          done_jobs;
    int          grants[$];
    logic [31:0] last_prod;
    int          last_id;
    int          exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        running   = 1'b0;
        age       = 0;
        ptr       = 0;
        hold_left = 0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        grants.delete();
    endtask

    // One clock cycle: drive clients, compare against the model, advance the model past the edge.
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        int g;
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 3) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = rand_op();
                    pb[i] = rand_op();
                end else if (pv[i] && $urandom_range(0, 15) == 0) begin
                    pv[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]        = pv[i];
            bus.req_a[16*i +: 16]   = pa[i];
            bus.req_b[16*i +: 16]   = pb[i];
        end
        if (running && age > CORE_LAT) begin
            if (hold_left > 0) begin
                bus.rsp_ready = 1'b0;
                hold_left--;
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end else begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end
        #1;
        exp_ready = '0;
        g = -1;
        if (!running) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && pv[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("m_en", 32'(bus.m_en), 32'(running && age <= CORE_LAT));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(running && age > CORE_LAT));
        if (running && age <= CORE_LAT) begin
            check("m_a", 32'(bus.m_a), 32'(job_a));
            check("m_b", 32'(bus.m_b), 32'(job_b));
        end
        if (running && age > CORE_LAT) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(job_id_m));
            check("rsp_prod", bus.rsp_prod, mul16(job_a, job_b));
            check("rsp_err", 32'(bus.rsp_err), 32'(0));
        end
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grants.push_back(i);
        if (running && age > CORE_LAT && bus.rsp_ready) begin
            running   = 1'b0;
            done_jobs++;
            last_prod = bus.rsp_prod;
            last_id   = int'(bus.rsp_id);
        end else if (running) begin
            age++;
            if (age == CORE_LAT + 1) hold_left = (bp_fixed >= 0) ? bp_fixed : $urandom_range(0, 3);
        end
        if (g >= 0) begin
            running  = 1'b1;
            age      = 0;
            job_id_m = g;
            job_a    = pa[g];
            job_b    = pb[g];
            pv[g]    = 1'b0;
            ptr      = (g + 1) % NREQ;
            if (cont_mode) begin
                pv[g] = 1'b1;
                pa[g] = rand_op();
                pb[g] = rand_op();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_jobs(input int n, input int budget);
        int start;
        int cycles;
        start  = done_jobs;
        cycles = 0;
        while (done_jobs - start < n && cycles < budget) begin
            step();
            cycles++;
        end
        check("jobs_completed", 32'(done_jobs - start), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        done_jobs = 0;
        bp_fixed  = 0;
        cont_mode = 1'b0;
        rand_mode = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end

        // Reset with every client requesting: no acceptance, all outputs at reset values.
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = {NREQ{16'h1234}};
        bus.req_b     = {NREQ{16'h5678}};
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check("rst_m_en", 32'(bus.m_en), 32'(0));
        check("rst_m_a", 32'(bus.m_a), 32'(0));
        check("rst_m_b", 32'(bus.m_b), 32'(0));
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
        check("rst_rsp_prod", bus.rsp_prod, 32'(0));
        check("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
        bus.req_valid = '0;
        rst = 1'b0;
        model_reset();

        // Single request from client 0.
        pv[0] = 1'b1; pa[0] = 16'd3; pb[0] = 16'd5;
        run_jobs(1, 60);
        check("single_prod", last_prod, 32'd15);
        check("single_id", 32'(last_id), 32'(0));

        // Signed operands from client 2.
        pv[2] = 1'b1; pa[2] = 16'hFFFE; pb[2] = 16'd7;
        run_jobs(1, 60);
        check("neg_prod", last_prod, 32'hFFFF_FFF2);
        check("neg_id", 32'(last_id), 32'(2));
        pv[2] = 1'b1; pa[2] = 16'h8000; pb[2] = 16'h8000;
        run_jobs(1, 60);
        check("minmin_prod", last_prod, 32'h4000_0000);

        // All clients requesting continuously from reset: strict rotation from 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b1;
            pa[i] = rand_op();
            pb[i] = rand_op();
        end
        cont_mode = 1'b1;
        run_jobs(8, 300);
        check("rr_grant_count", 32'(grants.size()), 32'(8));
        for (int i = 0; i < 8 && i < grants.size(); i++) begin
            check("rr_order", 32'(grants[i]), 32'(exp_order[i]));
        end

        // Backpressure: response held for 10 cycles while others keep requesting.
        bp_fixed = 10;
        run_jobs(2, 120);
        bp_fixed = 0;

        // Reset 8 cycles into RUN abandons the job and returns the pointer to 0.
        cont_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        step();
        pv[1] = 1'b1; pa[1] = 16'd11; pb[1] = 16'd13;
        for (int n = 0; n < 40 && !(running && age == 8); n++) step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_m_en", 32'(bus.m_en), 32'(0));
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("midrst_req_ready", 32'(bus.req_ready), 32'(0));
        rst = 1'b0;
        model_reset();
        pv[1] = 1'b1; pa[1] = 16'd2; pb[1] = 16'd9;
        pv[3] = 1'b1; pa[3] = rand_op(); pb[3] = rand_op();
        run_jobs(1, 60);
        check("postrst_id", 32'(last_id), 32'(1));
        check("postrst_prod", last_prod, 32'd18);
        run_jobs(1, 60);
        check("postrst_next_id", 32'(last_id), 32'(3));

        // Randomized traffic with random backpressure and valid drops.
        bp_fixed  = -1;
        rand_mode = 1'b1;
        run_jobs(40, 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit sequential Booth multiplier core among NREQ requesters.
- Accepts operand pairs over a valid/ready handshake and drives the core's en/A/B.
- Waits for the core's done, then returns the 32-bit signed product tagged with the requester index.
- Sits between the requester clients and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy NREQ <= 2**ID_W.
- TIMEOUT, 32, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has an operand pair.
- req_a  in  NREQ*16  packed multiplicands; requester i at [16i+15:16i].
- req_b  in  NREQ*16  packed multipliers; same packing.
- req_ready  out  NREQ  one-hot (or zero) acceptance strobe.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_prod  out  32  signed product A*B.
- rsp_err  out  1  watchdog abort flag; constant 0 without the optional feature.
- m_en  out  1  core enable; low clears the core.
- m_a  out  16  core operand A.
- m_b  out  16  core operand B.
- m_prod  in  32  core product.
- m_done  in  1  core done.

Behaviour:
- Core contract:
  - m_en low for >=1 cycle clears the core.
  - With m_en held high and operands stable, m_done rises 18 edges after m_en rises.
  - m_prod is valid while m_done is high.
  - m_done stays high until m_en drops.
- Reset (rst high at an edge):
  - state=IDLE, rr_ptr=0.
  - m_en=0, m_a=0, m_b=0.
  - rsp_valid=0, rsp_id=0, rsp_prod=0, rsp_err=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation abandons the in-flight job with no response; m_en drops, which clears the core.
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - m_en=0.
  - Grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[grant]=1, combinational from req_valid and state; all other bits 0.
  - On an edge with any req_valid: latch req_a/req_b of grant into m_a/m_b, latch grant as job id, rr_ptr=(grant+1) mod NREQ, go to RUN.
  - No req_valid: stay, rr_ptr unchanged.
- RUN:
  - m_en=1; m_a/m_b held constant.
  - req_ready=0.
  - On an edge with m_done=1: rsp_prod=m_prod, rsp_id=job id, rsp_err=0, rsp_valid=1, go to RESP.
- RESP:
  - m_en=0; rsp_* held stable.
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
  - RESP lasts >=1 cycle, so the core always sees >=1 cycle of m_en=0 before the next job; the next job may be granted on the cycle after the response handshake.
- Latency:
  - Accepting edge E0 -> m_en high after E0.
  - rsp_valid high after E19, i.e. 19 cycles with an immediate rsp_ready.
  - Minimum job spacing 21 cycles.
- Fairness:
  - A continuously requesting client waits at most NREQ-1 jobs.
  - Simultaneous requests are resolved by rr_ptr only.
- Requesters must hold req_valid/req_a/req_b stable until their req_ready; dropping valid before grant is permitted.
- Product is signed 2's complement; m_prod is passed through unmodified.
- A req_valid arriving in RUN/RESP is ignored until IDLE.

Optional Feature:
- Macro: BOOTH_MULT_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT with m_done still 0: rsp_valid=1, rsp_err=1, rsp_prod=0, rsp_id=job id, go to RESP.
  - m_en then drops, clearing the core.
- Undefined: no counter; RUN waits indefinitely; rsp_err tied 0.

Test Plan:
- Reset then single request: req0 A=3, B=5 -> req_ready[0] pulses once; rsp_valid 19 cycles later with rsp_id=0, rsp_prod=15.
- Signed operands: req2 A=16'hFFFE, B=7 -> rsp_prod=32'hFFFFFFF2, rsp_id=2; second job A=16'h8000, B=16'h8000 -> 32'h40000000.
- All four requesting continuously from reset -> grant order 0,1,2,3,0,...; each result matches its own operands and id.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_* stable, m_en=0, no new req_ready until rsp_ready=1; next grant on the following cycle.
- Reset asserted 8 cycles into RUN -> next cycle m_en=0, rsp_valid=0, rr_ptr=0; a fresh req1 A=2, B=9 -> rsp_prod=18.
- With BOOTH_MULT_ARB_TIMEOUT_EN, TIMEOUT=10 and core model holding m_done=0 -> rsp_valid with rsp_err=1, rsp_prod=0 after 11 cycles; the following job completes normally.
